// File: rtl/vk_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vk_arb_pkg
//  Purpose  : Shared widths, round-robin pick result type and picker function
//             for the vk_to_string arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package vk_arb_pkg;

  localparam int VK_CODE_W = 32;
  localparam int VK_RET_W  = 64;
  localparam int RR_MAX    = 16;

  typedef struct packed {
    logic       any;
    logic [3:0] idx;
  } rr_pick_t;

  // First valid index at or after ptr, wrapping modulo num.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] valid,
                                       input logic [3:0]        ptr,
                                       input int unsigned       num);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      cand = (32'(ptr) + k) % num;
      if ((k < num) && !res.any && valid[cand[3:0]]) begin
        res.any = 1'b1;
        res.idx = cand[3:0];
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vk_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : vk_tag_fifo
//  Purpose  : In-order requester-tag FIFO. Push is refused only when full
//             without a simultaneous pop; pop is ignored when empty.
//  Revision : 1.0  initial release
// ============================================================================
module vk_tag_fifo #(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             w_do_push, w_do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CW'(DEPTH));
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);

  // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (w_do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/vk_to_string_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vk_to_string_arbiter
//  Purpose  : Round-robin sharing of one pipelined vk_to_string component
//             among NUM_REQ requesters; returns routed back by an in-order
//             tag FIFO. Call and return paths are combinational.
//  Revision : 1.0  initial release
// ============================================================================
module vk_to_string_arbiter
  import vk_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int MAX_INFLIGHT = 8,
  localparam int TAG_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*VK_CODE_W-1:0] req_code,
  output logic [NUM_REQ-1:0]           req_stall,
  output logic [NUM_REQ-1:0]           resp_valid,
  input  logic [NUM_REQ-1:0]           resp_stall,
  output logic [VK_RET_W-1:0]          resp_data,
  output logic                         comp_start,
  output logic [VK_CODE_W-1:0]         comp_code,
  input  logic                         comp_busy,
  input  logic                         comp_done,
  output logic                         comp_stall,
  input  logic [VK_RET_W-1:0]          comp_returndata,
  output logic [CNT_W-1:0]             inflight,
  output logic                         proto_err
);

  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             proto_err_q, proto_err_d;
  rr_pick_t         w_pick;
  logic [TAG_W-1:0] w_winner, w_head;
  logic             w_accept, w_pop, w_empty, w_full, w_head_stall;

  assign w_pick     = rr_pick(RR_MAX'(req_valid), 4'(rr_ptr_q), NUM_REQ);
  assign w_winner   = TAG_W'(w_pick.idx);
  // Outputs are gated by resetn so they show reset values while reset is held.
  assign comp_start = resetn & w_pick.any & ~w_full;
  assign comp_code  = req_code[VK_CODE_W*int'(w_winner) +: VK_CODE_W];
  assign w_accept   = comp_start & ~comp_busy;
  assign resp_data  = comp_returndata;
  assign comp_stall = resetn & ~w_empty & w_head_stall;
  assign w_pop      = comp_done & ~comp_stall & ~w_empty;
  assign proto_err  = proto_err_q;

  vk_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk_i       (clock),
    .rst_ni      (resetn),
    .push_i      (w_accept),
    .push_data_i (w_winner),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .empty_o     (w_empty),
    .full_o      (w_full),
    .count_o     (inflight)
  );

  // Per-requester decode: grant stall, head back-pressure select, return routing.
  always_comb begin
    req_stall    = '1;
    resp_valid   = '0;
    w_head_stall = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_accept && (TAG_W'(i) == w_winner)) req_stall[i] = 1'b0;
      if (TAG_W'(i) == w_head) begin
        w_head_stall  = resp_stall[i];
        resp_valid[i] = resetn & comp_done & ~w_empty;
      end
    end
  end

  // Next pointer after a grant and sticky protocol-error detection.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    proto_err_d = proto_err_q | (comp_done & w_empty);
    if (w_accept) begin
      if (w_winner == TAG_W'(NUM_REQ - 1)) rr_ptr_d = '0;
      else                                 rr_ptr_d = w_winner + 1'b1;
    end
  end

  // Arbitration pointer and error flag registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vk_to_string_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vk_to_string_arbiter
//  Purpose  : Self-checking bench: directed scenarios plus random traffic
//             against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vk_to_string_arbiter;

  localparam int N = 4;
  localparam int M = 8;

  logic           clock = 1'b0;
  logic           resetn;
  logic [N-1:0]   req_valid, req_stall, resp_valid, resp_stall;
  logic [N*32-1:0] req_code;
  logic [63:0]    resp_data, comp_returndata;
  logic           comp_start, comp_busy, comp_done, comp_stall, proto_err;
  logic [31:0]    comp_code;
  logic [3:0]     inflight;

  vk_to_string_arbiter #(.NUM_REQ(N), .MAX_INFLIGHT(M)) dut (
    .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_code(req_code),
    .req_stall(req_stall), .resp_valid(resp_valid), .resp_stall(resp_stall),
    .resp_data(resp_data), .comp_start(comp_start), .comp_code(comp_code),
    .comp_busy(comp_busy), .comp_done(comp_done), .comp_stall(comp_stall),
    .comp_returndata(comp_returndata), .inflight(inflight), .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model state: outstanding tags in call order, pointer, error flag.
  int tags[$];
  int ptr_m;
  bit perr_m;

  logic [N-1:0] e_req_stall, e_resp_valid;
  logic         e_start, e_accept, e_comp_stall, e_pop;
  int           e_win;
  logic [31:0]  e_code;

  function automatic void model_eval();
    bit any;
    int idx;
    any   = 1'b0;
    e_win = 0;
    for (int k = 0; k < N; k++) begin
      idx = (ptr_m + k) % N;
      if (!any && req_valid[idx]) begin
        any   = 1'b1;
        e_win = idx;
      end
    end
    e_start     = any && (tags.size() < M);
    e_accept    = e_start && !comp_busy;
    e_req_stall = '1;
    if (e_accept) e_req_stall[e_win] = 1'b0;
    e_code       = req_code[e_win*32 +: 32];
    e_resp_valid = (comp_done && tags.size() > 0) ? (4'b0001 << tags[0]) : 4'b0000;
    e_comp_stall = (tags.size() > 0) && resp_stall[tags[0]];
    e_pop        = comp_done && !e_comp_stall && (tags.size() > 0);
  endfunction

  task automatic adv();
    model_eval();
    if (comp_done && tags.size() == 0) perr_m = 1'b1;
    if (e_pop) void'(tags.pop_front());
    if (e_accept) begin
      tags.push_back(e_win);
      ptr_m = (e_win + 1) % N;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req_valid = '0; req_code = '0; resp_stall = '0;
    comp_busy = 1'b0; comp_done = 1'b0; comp_returndata = '0;
    tags.delete(); ptr_m = 0; perr_m = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    req_valid = 4'hF; req_code = '0; resp_stall = 4'hF;
    comp_busy = 1'b0; comp_done = 1'b1; comp_returndata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (comp_start !== 1'b0) begin failures++; $display("FAIL rst_start got=%b exp=0", comp_start); end
    checks++; if (req_stall !== 4'hF) begin failures++; $display("FAIL rst_req_stall got=%b exp=1111", req_stall); end
    checks++; if (resp_valid !== 4'h0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0000", resp_valid); end
    checks++; if (comp_stall !== 1'b0) begin failures++; $display("FAIL rst_comp_stall got=%b exp=0", comp_stall); end
    checks++; if (inflight !== 4'd0 || proto_err !== 1'b0) begin failures++; $display("FAIL rst_state got=%0d/%b exp=0/0", inflight, proto_err); end
    do_reset();
  endtask

  task automatic test_single();
    logic [63:0] rd;
    do_reset();
    req_valid = 4'b0001; req_code[31:0] = 32'h41;
    @(negedge clock);
    checks++; if (req_stall !== 4'b1110) begin failures++; $display("FAIL single_grant got=%b exp=1110", req_stall); end
    checks++; if (comp_start !== 1'b1 || comp_code !== 32'h41) begin failures++; $display("FAIL single_call got=%b/%h exp=1/41", comp_start, comp_code); end
    adv();
    req_valid = '0;
    @(negedge clock);
    checks++; if (inflight !== 4'd1) begin failures++; $display("FAIL single_inflight1 got=%0d exp=1", inflight); end
    adv();
    adv();
    comp_done = 1'b1; rd = {$urandom, $urandom}; comp_returndata = rd;
    @(negedge clock);
    checks++; if (resp_valid !== 4'b0001) begin failures++; $display("FAIL single_resp got=%b exp=0001", resp_valid); end
    checks++; if (resp_data !== rd) begin failures++; $display("FAIL single_data got=%h exp=%h", resp_data, rd); end
    adv();
    comp_done = 1'b0;
    @(negedge clock);
    checks++; if (inflight !== 4'd0) begin failures++; $display("FAIL single_inflight0 got=%0d exp=0", inflight); end
  endtask

  task automatic test_fairness();
    do_reset();
    req_valid = 4'hF;
    for (int j = 0; j < N; j++) req_code[j*32 +: 32] = 32'h100 + j;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checks++;
      if (req_stall !== ~(4'b0001 << (i % 4)) || comp_code !== 32'h100 + (i % 4)) begin
        failures++; $display("FAIL fair_grant i=%0d got=%b/%h exp_idx=%0d", i, req_stall, comp_code, i % 4);
      end
      adv();
    end
    req_valid = '0; comp_done = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checks++;
      if (resp_valid !== (4'b0001 << (i % 4))) begin
        failures++; $display("FAIL fair_route i=%0d got=%b exp=%b", i, resp_valid, 4'b0001 << (i % 4));
      end
      adv();
    end
    comp_done = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0100; adv();
    req_valid = 4'b0001; adv();
    req_valid = '0; comp_done = 1'b1; resp_stall = 4'b0100;
    @(negedge clock);
    checks++; if (comp_stall !== 1'b1 || resp_valid !== 4'b0100) begin failures++; $display("FAIL bp_stall got=%b/%b exp=1/0100", comp_stall, resp_valid); end
    adv();
    @(negedge clock);
    checks++; if (inflight !== 4'd2) begin failures++; $display("FAIL bp_hold got=%0d exp=2", inflight); end
    resp_stall = '0;
    #1;
    checks++; if (comp_stall !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", comp_stall); end
    adv();
    @(negedge clock);
    checks++; if (inflight !== 4'd1 || resp_valid !== 4'b0001) begin failures++; $display("FAIL bp_next got=%0d/%b exp=1/0001", inflight, resp_valid); end
    adv();
    comp_done = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    req_valid = 4'hF;
    repeat (8) adv();
    @(negedge clock);
    checks++; if (comp_start !== 1'b0 || req_stall !== 4'hF) begin failures++; $display("FAIL full_block got=%b/%b exp=0/1111", comp_start, req_stall); end
    checks++; if (inflight !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", inflight); end
    adv();
    comp_done = 1'b1;
    @(negedge clock);
    checks++; if (comp_start !== 1'b0 || resp_valid !== 4'b0001) begin failures++; $display("FAIL full_popcycle got=%b/%b exp=0/0001", comp_start, resp_valid); end
    adv();
    comp_done = 1'b0;
    @(negedge clock);
    checks++; if (comp_start !== 1'b1 || req_stall !== 4'b1110 || inflight !== 4'd7) begin
      failures++; $display("FAIL full_resume got=%b/%b/%0d exp=1/1110/7", comp_start, req_stall, inflight);
    end
    adv();
    req_valid = '0;
  endtask

  task automatic test_simul();
    do_reset();
    req_valid = 4'hF;
    repeat (5) adv();
    comp_done = 1'b1;
    @(negedge clock);
    checks++; if (inflight !== 4'd5 || resp_valid !== 4'b0001 || req_stall !== 4'b1101) begin
      failures++; $display("FAIL simul_cycle got=%0d/%b/%b exp=5/0001/1101", inflight, resp_valid, req_stall);
    end
    adv();
    req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (resp_valid !== (4'b0001 << ((i + 1) % 4)) || (i == 0 && inflight !== 4'd5)) begin
        failures++; $display("FAIL simul_order i=%0d got=%b/%0d exp=%b", i, resp_valid, inflight, 4'b0001 << ((i + 1) % 4));
      end
      adv();
    end
    comp_done = 1'b0;
  endtask

  task automatic test_random();
    bit gw;
    int gi;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_code[i*32 +: 32] = $urandom;
        end
      comp_busy = ($urandom_range(0, 3) == 0);
      resp_stall = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      comp_done = (tags.size() > 0) && ($urandom_range(0, 1) == 1);
      comp_returndata = {$urandom, $urandom};
      @(negedge clock);
      model_eval();
      checks++; if (comp_start !== e_start || req_stall !== e_req_stall) begin failures++; $display("FAIL rnd_call c=%0d got=%b/%b exp=%b/%b", c, comp_start, req_stall, e_start, e_req_stall); end
      checks++; if (e_start && comp_code !== e_code) begin failures++; $display("FAIL rnd_code c=%0d got=%h exp=%h", c, comp_code, e_code); end
      checks++; if (resp_valid !== e_resp_valid || comp_stall !== e_comp_stall) begin failures++; $display("FAIL rnd_ret c=%0d got=%b/%b exp=%b/%b", c, resp_valid, comp_stall, e_resp_valid, e_comp_stall); end
      checks++; if (resp_data !== comp_returndata) begin failures++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, resp_data, comp_returndata); end
      checks++; if (inflight !== 4'(tags.size()) || proto_err !== perr_m) begin failures++; $display("FAIL rnd_state c=%0d got=%0d/%b exp=%0d/%b", c, inflight, proto_err, tags.size(), perr_m); end
      gw = e_accept; gi = e_win;
      adv();
      if (gw) req_valid[gi] = 1'b0;
    end
    req_valid = '0; comp_done = 1'b0; comp_busy = 1'b0;
  endtask

  task automatic test_proto_err();
    do_reset();
    comp_done = 1'b1; resp_stall = 4'hF;
    @(negedge clock);
    checks++; if (resp_valid !== 4'h0 || comp_stall !== 1'b0 || proto_err !== 1'b0) begin
      failures++; $display("FAIL perr_drop got=%b/%b/%b exp=0000/0/0", resp_valid, comp_stall, proto_err);
    end
    adv();
    comp_done = 1'b0; resp_stall = '0;
    @(negedge clock);
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL perr_set got=%b exp=1", proto_err); end
    req_valid = 4'b0010; adv();
    req_valid = '0; comp_done = 1'b1; adv();
    comp_done = 1'b0;
    @(negedge clock);
    checks++; if (proto_err !== 1'b1 || inflight !== 4'd0) begin failures++; $display("FAIL perr_sticky got=%b/%0d exp=1/0", proto_err, inflight); end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'hF;
    repeat (3) adv();
    comp_done = 1'b1; resp_stall = 4'hF;
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (comp_start !== 1'b0 || req_stall !== 4'hF || resp_valid !== 4'h0 || comp_stall !== 1'b0) begin
      failures++; $display("FAIL midrst_out got=%b/%b/%b/%b exp=0/1111/0000/0", comp_start, req_stall, resp_valid, comp_stall);
    end
    checks++; if (inflight !== 4'd0 || proto_err !== 1'b0) begin failures++; $display("FAIL midrst_state got=%0d/%b exp=0/0", inflight, proto_err); end
    do_reset();
    req_valid = 4'b1000;
    @(negedge clock);
    checks++; if (req_stall !== 4'b0111) begin failures++; $display("FAIL midrst_after got=%b exp=0111", req_stall); end
    adv();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_full();
    test_simul();
    test_random();
    test_proto_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
